// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit driving one HI/LO register-file write port.
// Multiply done MUL_LATENCY cycles after acceptance, divide after 34; flush cancels, start while busy is dropped.
module muldiv_unit #(
  parameter int MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        hi_wen,
  output logic [31:0] hi_wdata,
  output logic        lo_wen,
  output logic [31:0] lo_wdata
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [4:0] MUL_LAST = 5'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);

  state_t      r_state, w_state_nxt;
  logic        r_uns;
  logic [31:0] r_a, r_b, r_rem, r_quo, r_hi, r_lo;
  logic [4:0]  r_cnt;
  logic        r_busy, r_done;

  logic        w_ld, w_busy_nxt, w_done_nxt;
  logic [4:0]  w_cnt_nxt;
  logic [31:0] w_rem_nxt, w_quo_nxt, w_hi_nxt, w_lo_nxt;

  function automatic logic [31:0] f_abs(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // With a 1-cycle latency the product is taken straight from the issuing operands.
  logic [31:0] w_ma, w_mb;
  logic        w_msgn;
  logic [63:0] w_ma_x, w_mb_x, w_prod;
  assign w_ma   = (r_state == IDLE) ? src_a : r_a;
  assign w_mb   = (r_state == IDLE) ? src_b : r_b;
  assign w_msgn = (r_state == IDLE) ? ~op[0] : ~r_uns;
  assign w_ma_x = {{32{w_msgn & w_ma[31]}}, w_ma};
  assign w_mb_x = {{32{w_msgn & w_mb[31]}}, w_mb};
  assign w_prod = w_ma_x * w_mb_x;

  // Restoring divider: 33-bit shifted partial remainder against the divisor magnitude.
  logic [31:0] w_dvs, w_a_mag, w_sub, w_q_fix, w_r_fix;
  logic [32:0] w_shift;
  logic        w_fits;
  assign w_dvs   = r_uns ? r_b : f_abs(r_b);
  assign w_a_mag = op[0] ? src_a : f_abs(src_a);
  assign w_shift = {r_rem, r_quo[31]};
  assign w_fits  = (w_shift >= {1'b0, w_dvs});
  assign w_sub   = w_shift[31:0] - w_dvs;

  assign w_q_fix = r_uns                 ? r_quo :
                   (r_b == 32'd0)        ? 32'hFFFF_FFFF :
                   (r_a[31] ^ r_b[31])   ? (~r_quo + 32'd1) : r_quo;
  assign w_r_fix = (r_uns || !r_a[31]) ? r_rem : (~r_rem + 32'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_ld        = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_rem_nxt   = r_rem;
    w_quo_nxt   = r_quo;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      IDLE: begin
        if (start && !flush) begin
          w_ld      = 1'b1;
          w_cnt_nxt = 5'd0;
          if (op[1]) begin
            w_state_nxt = DIV;
            w_busy_nxt  = 1'b1;
            w_rem_nxt   = 32'd0;
            w_quo_nxt   = w_a_mag;
          end else if (MUL_LATENCY == 1) begin
            w_done_nxt           = 1'b1;
            {w_hi_nxt, w_lo_nxt} = w_prod;
          end else begin
            w_state_nxt = MUL;
            w_busy_nxt  = 1'b1;
          end
        end
      end
      MUL: begin
        if (r_cnt == MUL_LAST) begin
          w_state_nxt          = IDLE;
          w_done_nxt           = 1'b1;
          {w_hi_nxt, w_lo_nxt} = w_prod;
        end else begin
          w_cnt_nxt  = r_cnt + 5'd1;
          w_busy_nxt = 1'b1;
        end
      end
      DIV: begin
        w_busy_nxt = 1'b1;
        w_rem_nxt  = w_fits ? w_sub : w_shift[31:0];
        w_quo_nxt  = {r_quo[30:0], w_fits};
        w_cnt_nxt  = r_cnt + 5'd1;
        if (r_cnt == 5'd31) w_state_nxt = FIX;
      end
      FIX: begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
        w_hi_nxt    = w_r_fix;
        w_lo_nxt    = w_q_fix;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Flush cancels whatever would have completed; the previous result stays visible.
    if (flush) begin
      w_state_nxt = IDLE;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_hi_nxt    = r_hi;
      w_lo_nxt    = r_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_cnt  <= 5'd0;
      r_rem  <= 32'd0;
      r_quo  <= 32'd0;
      r_uns  <= 1'b0;
      r_a    <= 32'd0;
      r_b    <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_hi   <= w_hi_nxt;
      r_lo   <= w_lo_nxt;
      r_cnt  <= w_cnt_nxt;
      r_rem  <= w_rem_nxt;
      r_quo  <= w_quo_nxt;
      if (w_ld) begin
        r_uns <= op[0];
        r_a   <= src_a;
        r_b   <= src_b;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign hi_wen   = r_done;
  assign lo_wen   = r_done;
  assign hi_wdata = r_hi;
  assign lo_wdata = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, randomized ops against an arithmetic model,
// and hand sequences for flush, ignored start, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done, hi_wen, lo_wen;
  logic [31:0] hi_wdata, lo_wdata;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  muldiv_unit #(.MUL_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .hi_wen(hi_wen), .hi_wdata(hi_wdata),
    .lo_wen(lo_wen), .lo_wdata(lo_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Reference results from plain integer arithmetic plus the architected special cases.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      la, lb;
    logic [63:0] r;
    sa = a;
    sb = b;
    case (o)
      2'd0: begin la = sa; lb = sb; r = la * lb; end
      2'd1: r = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0)                                  r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else                                             r = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else            r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Issues one op, then follows it to its done cycle. Returns in the done cycle.
  // A start is re-presented in busy cycle 'poke' and must be ignored.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_lat, input int poke, input string nm);
    int cyc;
    int bad;
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    bad = 0;
    while (!done && cyc < 60) begin
      if (busy !== 1'b1) bad++;
      if (hi_wdata !== last_hi || lo_wdata !== last_lo) bad++;
      start = (cyc == poke);
      op = 2'($urandom); src_a = $urandom; src_b = $urandom;
      tick();
      start = 1'b0;
      cyc++;
    end
    chk($sformatf("%s_done", nm), 64'(done), 64'd1);
    chk($sformatf("%s_lat", nm), 64'(cyc), 64'(exp_lat));
    chk($sformatf("%s_busy_hold", nm), 64'(bad), 64'd0);
    chk($sformatf("%s_flags", nm), {61'd0, busy, hi_wen, lo_wen}, 64'b011);
    chk($sformatf("%s_res", nm), {hi_wdata, lo_wdata}, exp);
    {last_hi, last_lo} = exp;
  endtask

  task automatic watch_done(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      tick();
      if (done || busy) cnt++;
    end
  endtask

  initial begin
    int          c;
    logic [1:0]  o;
    logic [31:0] a, b;

    vecs[0]  = '{2'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[3]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{2'd3, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC};
    vecs[5]  = '{2'd3, 32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF};
    vecs[6]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7]  = '{2'd3, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 32'hFFFF_FFFF};
    vecs[8]  = '{2'd2, 32'hFFFF_FF9C, 32'd0,        32'hFFFF_FF9C, 32'hFFFF_FFFF};
    vecs[9]  = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[10] = '{2'd1, 32'd2,         32'd3,        32'h0000_0000, 32'h0000_0006};

    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_flags", {60'd0, busy, done, hi_wen, lo_wen}, 64'd0);
    chk("rst_data", {hi_wdata, lo_wdata}, 64'd0);

    // Vectors issue back to back: each start lands in the previous done cycle.
    for (int i = 0; i < 11; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo},
             vecs[i].op[1] ? 34 : LAT, -1, $sformatf("vec%0d", i));
    tick();
    chk("done_pulse", {61'd0, done, hi_wen, lo_wen}, 64'd0);
    chk("idle_hold", {hi_wdata, lo_wdata}, {last_hi, last_lo});

    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 7 == 3) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
      run_op(o, a, b, model(o, a, b), o[1] ? 34 : LAT, -1, $sformatf("rnd%0d", i));
    end
    tick();

    // DIV accepted at cycle 0, flushed in cycle 10, MULTU issued in cycle 11.
    op = 2'd2; src_a = 32'd12345; src_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_flags", {62'd0, busy, done}, 64'd0);
    chk("flush_hold", {hi_wdata, lo_wdata}, {last_hi, last_lo});
    run_op(2'd1, 32'd2, 32'd3, 64'd6, LAT, -1, "flush_mul");
    watch_done(30, c);
    chk("flush_no_done", 64'(c), 64'd0);

    op = 2'd0; src_a = 32'd9; src_b = 32'd9; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("start_flush_busy", 64'(busy), 64'd0);
    watch_done(6, c);
    chk("start_flush_quiet", 64'(c), 64'd0);

    run_op(2'd2, 32'd1000, 32'd7, model(2'd2, 32'd1000, 32'd7), 34, 5, "ignore_start");
    run_op(2'd0, 32'hFFFF_FFF0, 32'd16, model(2'd0, 32'hFFFF_FFF0, 32'd16), LAT, 1, "b2b_mult");
    run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, model(2'd1, 32'h1234_5678, 32'h9ABC_DEF0), LAT, -1, "b2b_multu");
    tick();

    // Reset asserted in cycle 5 of a DIV.
    op = 2'd2; src_a = 32'd99; src_b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_flags", {60'd0, busy, done, hi_wen, lo_wen}, 64'd0);
    chk("midrst_data", {hi_wdata, lo_wdata}, 64'd0);
    watch_done(40, c);
    chk("midrst_no_done", 64'(c), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
